// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the block-RAM controllers: FSM encoding, client ids
// and default RAM geometry.
package ram_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic CLIENT_A = 1'b0;
  localparam logic CLIENT_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the client that was not
// granted last wins.
module rr_pick2
  import ram_ctrl_pkg::*;
(
  input  logic eligible_a,
  input  logic eligible_b,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // Select the winner among the eligible clients.
  always_comb begin
    valid  = eligible_a | eligible_b;
    winner = CLIENT_A;
    if (eligible_a && eligible_b) begin
      winner = (last_grant == CLIENT_A) ? CLIENT_B : CLIENT_A;
    end else if (eligible_b) begin
      winner = CLIENT_B;
    end else begin
      winner = CLIENT_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between two
// held-request clients; every output is driven from a flop.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = ram_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e              state_q, state_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic                last_grant_q, last_grant_d;
  logic                winner_q, winner_d;
  logic                eligible_a_s, eligible_b_s;
  logic                pick_valid_s, pick_winner_s;

  // A client still in its ack cycle is not eligible, so a held req cannot be re-granted.
  assign eligible_a_s = a_req & ~a_ack_q;
  assign eligible_b_s = b_req & ~b_ack_q;

  rr_pick2 u_pick (
    .eligible_a (eligible_a_s),
    .eligible_b (eligible_b_s),
    .last_grant (last_grant_q),
    .valid      (pick_valid_s),
    .winner     (pick_winner_s)
  );

  // Next-state and next-output logic for the access sequence.
  always_comb begin
    state_d      = state_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    rdata_d      = rdata_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          winner_d = pick_winner_s;
          state_d  = ISSUE;
          if (pick_winner_s == CLIENT_A) begin
            ram_we_d   = a_we;
            ram_addr_d = a_addr;
            ram_din_d  = a_wdata;
          end else begin
            ram_we_d   = b_we;
            ram_addr_d = b_addr;
            ram_din_d  = b_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rdata_d      = ram_dout;
        last_grant_d = winner_q;
        state_d      = IDLE;
        if (winner_q == CLIENT_A) begin
          a_ack_d = 1'b1;
        end else begin
          b_ack_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      rdata_q      <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      last_grant_q <= CLIENT_B;
      winner_q     <= CLIENT_A;
    end else begin
      state_q      <= state_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      rdata_q      <= rdata_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign rdata    = rdata_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural write-first 256x16 RAM;
// inputs change and outputs are sampled on the falling edge.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] rdata;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [15:0] mem [0:255];

  int checks_cnt = 0;
  int fail_cnt   = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .rdata    (rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Write-first synchronous RAM model, one cycle read latency.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    32'(ram_we),   32'h0);
    chk({tag, "_addr"},  32'(ram_addr), 32'h0);
    chk({tag, "_din"},   32'(ram_din),  32'h0);
    chk({tag, "_rdata"}, 32'(rdata),    32'h0);
    chk({tag, "_aack"},  32'(a_ack),    32'h0);
    chk({tag, "_back"},  32'(b_ack),    32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h01] = 16'h1111;
    mem[8'h02] = 16'h2222;
    ram_dout = 16'h0000;
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 16'h0000;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 16'h0000;
    tick();
    do_reset();
    chk_reset_vals("rst");

    // A write 0x10 <= 0xFF3C
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 16'hFF3C;
    tick();
    chk("wr_c1_we",   32'(ram_we),   32'h1);
    chk("wr_c1_addr", 32'(ram_addr), 32'h10);
    chk("wr_c1_din",  32'(ram_din),  32'hFF3C);
    tick();
    chk("wr_c2_we",   32'(ram_we),   32'h0);
    chk("wr_c2_ack",  32'(a_ack),    32'h0);
    tick();
    chk("wr_c3_ack",   32'(a_ack), 32'h1);
    chk("wr_c3_back",  32'(b_ack), 32'h0);
    chk("wr_c3_rdata", 32'(rdata), 32'hFF3C);
    a_req = 1'b0; a_we = 1'b0;
    tick();
    chk("wr_c4_ack", 32'(a_ack), 32'h0);

    // A read 0x10
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    tick();
    chk("rd_c1_we",   32'(ram_we),   32'h0);
    chk("rd_c1_addr", 32'(ram_addr), 32'h10);
    tick();
    chk("rd_c2_we",  32'(ram_we), 32'h0);
    chk("rd_c2_ack", 32'(a_ack),  32'h0);
    tick();
    chk("rd_c3_we",    32'(ram_we), 32'h0);
    chk("rd_c3_ack",   32'(a_ack),  32'h1);
    chk("rd_c3_rdata", 32'(rdata),  32'hFF3C);
    a_req = 1'b0;
    tick();

    // Simultaneous requests after reset: A wins, B granted in A's ack cycle
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
    tick();
    chk("tie_c1_addr", 32'(ram_addr), 32'h01);
    tick();
    tick();
    chk("tie_c3_aack",  32'(a_ack), 32'h1);
    chk("tie_c3_back",  32'(b_ack), 32'h0);
    chk("tie_c3_rdata", 32'(rdata), 32'h1111);
    a_req = 1'b0;
    tick();
    chk("tie_c4_addr", 32'(ram_addr), 32'h02);
    tick();
    tick();
    chk("tie_c6_back",  32'(b_ack), 32'h1);
    chk("tie_c6_aack",  32'(a_ack), 32'h0);
    chk("tie_c6_rdata", 32'(rdata), 32'h2222);
    b_req = 1'b0;
    tick();

    // Both hold req continuously for 12 cycles; last grant was B, so A first
    a_req = 1'b1; a_addr = 8'h01;
    b_req = 1'b1; b_addr = 8'h02;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("rr_c%0d_aack", k), 32'(a_ack), (k == 3 || k == 9)  ? 32'h1 : 32'h0);
      chk($sformatf("rr_c%0d_back", k), 32'(b_ack), (k == 6 || k == 12) ? 32'h1 : 32'h0);
      if (k == 3 || k == 9)  chk($sformatf("rr_c%0d_rd", k), 32'(rdata), 32'h1111);
      if (k == 6 || k == 12) chk($sformatf("rr_c%0d_rd", k), 32'(rdata), 32'h2222);
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // A holds req past its ack: no grant in the ack cycle, regrant from the next IDLE
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 16'h1234;
    tick();
    chk("hold_c1_we", 32'(ram_we), 32'h1);
    tick();
    tick();
    chk("hold_c3_ack", 32'(a_ack), 32'h1);
    tick();
    chk("hold_c4_we",  32'(ram_we), 32'h0);
    chk("hold_c4_ack", 32'(a_ack),  32'h0);
    tick();
    chk("hold_c5_we",   32'(ram_we),   32'h1);
    chk("hold_c5_addr", 32'(ram_addr), 32'h20);
    a_req = 1'b0; a_addr = 8'h99; a_wdata = 16'hDEAD; a_we = 1'b0;
    tick();
    chk("hold_c6_addr", 32'(ram_addr), 32'h20);
    chk("hold_c6_we",   32'(ram_we),   32'h0);
    tick();
    chk("hold_c7_ack",   32'(a_ack), 32'h1);
    chk("hold_c7_rdata", 32'(rdata), 32'h1234);
    tick();
    chk("hold_c8_ack", 32'(a_ack), 32'h0);

    // Reset in CAPTURE of a B read
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b_req = 1'b0;
    chk_reset_vals("midrst");
    tick();
    chk("midrst_c4_back", 32'(b_ack), 32'h0);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
    tick();
    chk("post_c1_addr", 32'(ram_addr), 32'h01);
    tick();
    tick();
    chk("post_c3_ack",   32'(a_ack), 32'h1);
    chk("post_c3_rdata", 32'(rdata), 32'h1111);
    a_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
